// File: rtl/img_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding and the
// helpers that derive pixel counts and bus widths from the image geometry.
package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_PROCESS,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

  // Default image geometry (30x30 RGB, shrink by 2).
  localparam int DEF_HIEGHT = 30;
  localparam int DEF_WIDTH  = 30;
  localparam int DEF_BPP    = 3;
  localparam int DEF_FACTOR = 2;

  // Total pixels in the source image.
  function automatic int calc_pexils(input int h, input int w);
    return h * w;
  endfunction

  // Width of one buffer word in bits.
  function automatic int calc_sz(input int bpp);
    return 8 * bpp;
  endfunction

  // Result-buffer address width.
  function automatic int calc_aw(input int h, input int w);
    return $clog2(h * w);
  endfunction

  // Number of pixels to transmit: shrunk image (mode=1) or full image.
  function automatic int calc_n(input int h, input int w, input int f, input logic mode);
    return mode ? (h / f) * (w / f) : h * w;
  endfunction

  localparam int DEF_PEXILS   = calc_pexils(DEF_HIEGHT, DEF_WIDTH);
  localparam int DEF_SZ       = calc_sz(DEF_BPP);
  localparam int DEF_AW       = calc_aw(DEF_HIEGHT, DEF_WIDTH);
  localparam int DEF_N_SHRINK = calc_n(DEF_HIEGHT, DEF_WIDTH, DEF_FACTOR, 1'b1);
  localparam int DEF_N_EFFECT = calc_n(DEF_HIEGHT, DEF_WIDTH, DEF_FACTOR, 1'b0);

endpackage

// File: rtl/frame_sequencer_if.sv
// Control, result-buffer and UART-side signals of the frame sequencer.
// master = sequencer side, slave = surrounding system.
interface frame_sequencer_if
  import img_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int SZ = DEF_SZ
) ();
  logic          start;
  logic          shr_or_eff;
  logic [1:0]    effect;
  logic          shrink_start;
  logic          effect_start;
  logic [1:0]    eff_sel;
  logic          unit_done;
  logic [AW-1:0] rd_addr;
  logic [SZ-1:0] rd_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          busy;
  logic          op_done;
  logic          frame_done;
  logic          err;

  modport master (
    input  start, shr_or_eff, effect, unit_done, rd_data, tx_ready,
    output shrink_start, effect_start, eff_sel, rd_addr, tx_valid, tx_data,
           busy, op_done, frame_done, err
  );

  modport slave (
    output start, shr_or_eff, effect, unit_done, rd_data, tx_ready,
    input  shrink_start, effect_start, eff_sel, rd_addr, tx_valid, tx_data,
           busy, op_done, frame_done, err
  );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for the (already debounced) start level.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);
  logic level_q;

  // Remember last level; reset treats it as high so a level already high at
  // reset release is not mistaken for a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: launches the shrink or effects unit, waits for it (with a
// timeout), then streams the result buffer to the UART MSB byte first.
module frame_sequencer
  import img_pkg::*;
#(
  parameter int HIEGHT  = DEF_HIEGHT,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BPP     = DEF_BPP,
  parameter int FACTOR  = DEF_FACTOR,
  parameter int TIMEOUT = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  frame_sequencer_if.master bus
);
  localparam int PEXILS = calc_pexils(HIEGHT, WIDTH);
  localparam int SZ     = calc_sz(BPP);
  localparam int AW     = calc_aw(HIEGHT, WIDTH);
  localparam int N_SHR  = calc_n(HIEGHT, WIDTH, FACTOR, 1'b1);
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam int BW     = (BPP > 1) ? $clog2(BPP) : 1;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [1:0]    eff_sel_q, eff_sel_d;
  logic [CW-1:0] proc_cnt_q, proc_cnt_d;
  logic [AW-1:0] pix_idx_q, pix_idx_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [SZ-1:0] shreg_q, shreg_d;
  logic          op_done_q, op_done_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;
  logic          start_rise;
  logic [AW-1:0] last_pix;

  edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (bus.start),
    .rise_o  (start_rise)
  );

  assign last_pix = mode_q ? AW'(N_SHR - 1) : AW'(PEXILS - 1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      eff_sel_q    <= '0;
      proc_cnt_q   <= '0;
      pix_idx_q    <= '0;
      byte_idx_q   <= '0;
      shreg_q      <= '0;
      op_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      eff_sel_q    <= eff_sel_d;
      proc_cnt_q   <= proc_cnt_d;
      pix_idx_q    <= pix_idx_d;
      byte_idx_q   <= byte_idx_d;
      shreg_q      <= shreg_d;
      op_done_q    <= op_done_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    eff_sel_d    = eff_sel_q;
    proc_cnt_d   = proc_cnt_q;
    pix_idx_d    = pix_idx_q;
    byte_idx_d   = byte_idx_q;
    shreg_d      = shreg_q;
    op_done_d    = op_done_q;
    frame_done_d = frame_done_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d      = ST_LAUNCH;
          mode_d       = bus.shr_or_eff;
          eff_sel_d    = bus.effect;
          proc_cnt_d   = '0;
          pix_idx_d    = '0;
          op_done_d    = 1'b0;
          frame_done_d = 1'b0;
          err_d        = 1'b0;
        end
      end
      ST_LAUNCH: state_d = ST_PROCESS;
      ST_PROCESS: begin
        proc_cnt_d = proc_cnt_q + CW'(1);
        // unit_done may still be high from the previous job on the first cycle
        if (proc_cnt_q != '0 && bus.unit_done) begin
          state_d   = ST_FETCH;
          op_done_d = 1'b1;
        end else if (proc_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d    = bus.rd_data;
        byte_idx_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          shreg_d = shreg_q << 8;
          if (byte_idx_q == BW'(BPP - 1)) begin
            if (pix_idx_q == last_pix) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end else begin
              pix_idx_d = pix_idx_q + AW'(1);
              state_d   = ST_FETCH;
            end
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
      ST_DONE: if (!bus.start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.shrink_start = (state_q == ST_LAUNCH) &&  mode_q;
  assign bus.effect_start = (state_q == ST_LAUNCH) && !mode_q;
  assign bus.eff_sel      = eff_sel_q;
  assign bus.rd_addr      = pix_idx_q;
  assign bus.tx_valid     = (state_q == ST_SEND);
  assign bus.tx_data      = shreg_q[SZ-1 -: 8];
  assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.op_done      = op_done_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer on a 4x4 image, 3 bytes per pixel.
module tb_frame_sequencer;
  localparam int H   = 4;
  localparam int W   = 4;
  localparam int BPP = 3;
  localparam int F   = 2;
  localparam int TO  = 50;
  localparam int AW  = 4;
  localparam int SZ  = 24;

  typedef struct packed {
    logic [7:0]    data;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sequencer_if #(.AW(AW), .SZ(SZ)) bus ();

  frame_sequencer #(
    .HIEGHT(H), .WIDTH(W), .BPP(BPP), .FACTOR(F), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_shr = 0;
  int         n_eff = 0;
  int         n_xfer = 0;
  logic       bp_en = 1'b0;
  int         bp_cnt = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'b0, bus.shrink_start, bus.effect_start, bus.eff_sel, bus.rd_addr,
            bus.tx_valid, bus.tx_data, bus.busy, bus.op_done, bus.frame_done, bus.err};
  endfunction

  // Result buffer model: word k = 0x0A0B0C + k, one-cycle read latency.
  always @(posedge clk) bus.rd_data <= 24'h0A0B0C + 24'(bus.rd_addr);

  // UART readiness: always ready, or toggling every 3 cycles under backpressure.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bp_cnt++;
      if (bp_cnt % 3 == 0) bus.tx_ready = ~bus.tx_ready;
    end else begin
      bp_cnt = 0;
      bus.tx_ready = 1'b1;
    end
  end

  // Monitor: counts launch pulses, checks stall stability, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (bus.shrink_start) n_shr++;
      if (bus.effect_start) n_eff++;
      if (bus.shrink_start || bus.effect_start)
        chk("launch_exclusive", 32'(bus.shrink_start & bus.effect_start), 32'd0);
      if (stall_pend) begin
        chk("stall_valid", 32'(bus.tx_valid), 32'd1);
        chk("stall_data", 32'(bus.tx_data), 32'(stall_data));
      end
      stall_pend = 1'b0;
      if (bus.tx_valid && bus.tx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bus.tx_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("xfer %0d: data %02h addr %0d (want %02h @ %0d)",
                   n_xfer, bus.tx_data, bus.rd_addr, mon_e.data, mon_e.addr);
          chk("tx_data", 32'(bus.tx_data), 32'(mon_e.data));
          chk("rd_addr", 32'(bus.rd_addr), 32'(mon_e.addr));
        end
      end else if (bus.tx_valid) begin
        stall_pend = 1'b1;
        stall_data = bus.tx_data;
      end
    end
  end

  task automatic push_bytes(input int npix, input int limit);
    logic [23:0] w;
    exp_t        ent;
    int          cnt;
    cnt = 0;
    for (int p = 0; p < npix; p++) begin
      w = 24'h0A0B0C + 24'(p);
      for (int b = 0; b < BPP; b++) begin
        if (cnt < limit) begin
          ent.data = w[23-8*b -: 8];
          ent.addr = AW'(p);
          exp_q.push_back(ent);
        end
        cnt++;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic mode, input logic [1:0] eff,
                           input int npix, input int hold, input bit glitch, input bit chk_tput);
    int s0, e0, x0, tput;
    bit got;
    push_bytes(npix, npix * BPP);
    s0 = n_shr; e0 = n_eff; x0 = n_xfer; tput = 0; got = 0;
    @(posedge clk); #1;
    bus.shr_or_eff = mode;
    bus.effect     = eff;
    bus.start      = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      if (bus.op_done && !bus.frame_done) tput++;
      if (cyc == 3) begin
        bus.effect     = ~eff;
        bus.shr_or_eff = ~mode;
      end
      if (glitch && cyc == 3) bus.start = 1'b0;
      if (glitch && cyc == 4) bus.start = 1'b1;
      if (cyc == hold) bus.start = 1'b0;
      if (cyc == 10) bus.unit_done = 1'b1;
      if (bus.frame_done && !bus.start) begin
        got = 1;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_frame_done_seen"}, 32'(got), 32'd1);
    bus.unit_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_frame_done_kept"}, 32'(bus.frame_done), 32'd1);
    chk({tag, "_op_done_kept"}, 32'(bus.op_done), 32'd1);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_eff_sel"}, 32'(bus.eff_sel), 32'(eff));
    chk({tag, "_shrink_pulses"}, 32'(n_shr - s0), 32'(mode));
    chk({tag, "_effect_pulses"}, 32'(n_eff - e0), 32'(!mode));
    chk({tag, "_bytes"}, 32'(n_xfer - x0), 32'(npix * BPP));
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    if (chk_tput) chk({tag, "_throughput_ok"}, 32'(tput <= npix * (BPP + 2)), 32'd1);
    exp_q.delete();
  endtask

  task automatic run_timeout();
    int s0, x0, pc;
    bit got;
    s0 = n_shr; x0 = n_xfer; pc = 0; got = 0;
    @(posedge clk); #1;
    bus.shr_or_eff = 1'b1;
    bus.effect     = 2'b00;
    bus.start      = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) bus.start = 1'b0;
      if (bus.err) begin
        got = 1;
        break;
      end
      if (bus.busy && !bus.shrink_start) pc++;
    end
    chk("timeout_err_seen", 32'(got), 32'd1);
    chk("timeout_process_cycles", 32'(pc), 32'(TO));
    chk("timeout_frame_done", 32'(bus.frame_done), 32'd0);
    chk("timeout_op_done", 32'(bus.op_done), 32'd0);
    chk("timeout_no_bytes", 32'(n_xfer - x0), 32'd0);
    chk("timeout_shrink_pulses", 32'(n_shr - s0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_busy_idle", 32'(bus.busy), 32'd0);
    chk("timeout_err_kept", 32'(bus.err), 32'd1);
  endtask

  task automatic run_reset_mid_frame();
    int s0, e0, x0;
    bit got;
    push_bytes(2, 5);
    x0 = n_xfer; got = 0;
    @(posedge clk); #1;
    bus.shr_or_eff = 1'b0;
    bus.effect     = 2'b10;
    bus.start      = 1'b1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(posedge clk);
      if (n_xfer - x0 >= 5) begin
        got = 1;
        break;
      end
      #1;
      if (cyc == 2) bus.start = 1'b0;
      if (cyc == 10) bus.unit_done = 1'b1;
    end
    chk("rst_five_bytes_seen", 32'(got), 32'd1);
    #1;
    bus.start = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_outputs_immediate", outs(), 32'd0);
    bus.unit_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = n_shr; e0 = n_eff; x0 = n_xfer;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_relaunch_shr", 32'(n_shr - s0), 32'd0);
    chk("rst_no_relaunch_eff", 32'(n_eff - e0), 32'd0);
    chk("rst_no_tx_after", 32'(n_xfer - x0), 32'd0);
    chk("rst_outputs_after_release", outs(), 32'd0);
    chk("rst_queue_left", 32'(exp_q.size()), 32'd0);
    bus.start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.shr_or_eff = 1'b0;
    bus.effect     = 2'b00;
    bus.unit_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame("shrink", 1'b1, 2'b01, 4, 2, 1'b0, 1'b1);
    run_frame("effect", 1'b0, 2'b10, 16, 2, 1'b0, 1'b1);
    bp_en = 1'b1;
    run_frame("backpressure", 1'b0, 2'b11, 16, 2, 1'b0, 1'b0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    run_timeout();
    run_frame("held_start", 1'b1, 2'b00, 4, 100, 1'b1, 1'b1);
    run_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): HIEGHT, 30, image rows; WIDTH, 30, image columns; BPP, 3, bytes per pixel; FACTOR, 2, shrink factor; TIMEOUT, 1_000_000, max cycles spent waiting on the processing unit.
REQ-002 Derived constants SHALL be PEXILS = HIEGHT*WIDTH, SZ = 8*BPP and AW = $clog2(PEXILS).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, debounced start level.
- shr_or_eff, in, 1, 1 = shrink, 0 = effect.
- effect, in, 2, effect selector.
- shrink_start, out, 1, one-cycle launch pulse to the shrink unit.
- effect_start, out, 1, one-cycle launch pulse to the effects unit.
- eff_sel, out, 2, latched effect selector.
- unit_done, in, 1, done level from the selected unit.
- rd_addr, out, AW, result-buffer read address.
- rd_data, in, SZ, result-buffer data, one-cycle read latency.
- tx_valid, out, 1, byte valid to the UART front end.
- tx_data, out, 8, byte to the UART front end.
- tx_ready, in, 1, UART accepts a byte.
- busy, out, 1, operation in progress.
- op_done, out, 1, processing finished.
- frame_done, out, 1, all bytes sent.
- err, out, 1, timeout occurred.

Function
REQ-004 The block SHALL implement the FSM states IDLE, LAUNCH, PROCESS, FETCH, LOAD, SEND and DONE.
REQ-005 IDLE SHALL go to LAUNCH on a rising edge of start only; a start level held high SHALL NOT relaunch.
REQ-006 On the IDLE->LAUNCH transition, shr_or_eff and effect SHALL be latched into mode and eff_sel; later changes to those inputs SHALL be ignored until the next IDLE.
REQ-007 LAUNCH SHALL last exactly 1 cycle: it asserts shrink_start if mode=1 or effect_start if mode=0 (never both), then goes to PROCESS.
REQ-008 PROCESS SHALL ignore unit_done in its first cycle, go to FETCH with op_done=1 on unit_done=1, and count cycles spent in PROCESS.
REQ-009 If the PROCESS cycle count reaches TIMEOUT, the block SHALL set err=1 and go to DONE without transmitting.
REQ-010 The pixel count N SHALL be (HIEGHT/FACTOR)*(WIDTH/FACTOR) (integer division) when mode=1, else PEXILS; pix_idx SHALL run from 0 to N-1.
REQ-011 FETCH SHALL drive rd_addr=pix_idx for 1 cycle; LOAD SHALL capture rd_data into a SZ-bit shift register, set byte_idx=0 and go to SEND.
REQ-012 In SEND, tx_valid SHALL be 1 and tx_data SHALL be the most-significant byte of the shift register.
REQ-013 A byte transfer SHALL occur on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-014 After each transfer the shift register SHALL shift left by 8 and byte_idx SHALL increment.
REQ-015 After byte BPP-1 is transferred, the block SHALL go to FETCH with pix_idx+1, or to DONE when pix_idx=N-1.
REQ-016 DONE SHALL assert frame_done=1 (unless err) and hold until start is low, then go to IDLE with op_done, frame_done and err kept until the next launch.
REQ-017 busy SHALL be 1 in every state except IDLE and DONE.
REQ-018 A start edge in any state other than IDLE SHALL be ignored.
REQ-019 Throughput SHALL be at most N*(BPP+2) cycles for transmission with tx_ready tied to 1.

Reset
REQ-020 Assertion of rst SHALL asynchronously force state IDLE, all counters 0, the shift register 0 and every output 0, including in mid-frame; no start pulse or tx_valid SHALL follow reset release until a new start edge.

Structure
REQ-021 The FSM state encoding and the derived constants (PEXILS, SZ, AW, N for both modes) SHALL live in the shared package img_pkg.
REQ-022 One sub-module, edge_detect (rising-edge detector on start), SHALL be used; the rest SHALL be flat.

Verification (HIEGHT=4, WIDTH=4, BPP=3, FACTOR=2)
REQ-023 Shrink frame: shr_or_eff=1, start pulse, unit_done high 10 cycles later, tx_ready=1 and buffer word k=0x0A0B0C+k -> exactly 1 shrink_start pulse, 4 pixels x 3 bytes sent as 0A,0B,0C,0A,0B,0D,... then frame_done=1.
REQ-024 Effect frame: shr_or_eff=0, effect=2'b10 -> effect_start pulse, eff_sel=2'b10, 48 bytes, rd_addr covering 0..15 in order.
REQ-025 Backpressure: tx_ready toggling every 3 cycles -> no byte lost or duplicated, tx_data stable while stalled.
REQ-026 Timeout: TIMEOUT=50 with unit_done stuck 0 -> err=1 at cycle 50 of PROCESS, zero tx_valid, DONE reached.
REQ-027 Reset mid-frame: rst asserted after byte 5 -> all outputs 0 immediately; start held high through release causes no relaunch.
REQ-028 Start held high for 100 cycles, plus a second start edge during PROCESS -> exactly 1 launch pulse.
